// File: rtl/csb_switch_ctrl.sv
// csb_switch_ctrl
//
// Sequencer for a two-input glitch-free clock switch. A switch request is
// carried out in four timed phases: DRAIN turns off the clock enable of the
// current source, SWAP moves the select to the new source with both enables
// off, and SETTLE enables the new source. If the target source dies during
// SWAP or SETTLE, REVERT puts the select back on the old source and then
// re-enables it. Each timed phase lasts a fixed number of clk cycles, counted
// by an 8-bit down-counter that is loaded on state entry.
//
// Parameters:
//   PRESELECT  "CLK0" or "CLK1": source selected out of reset
//   OFF_CYC    DRAIN length in cycles (1..255)
//   SEL_CYC    SWAP length in cycles (1..255)
//   ON_CYC     SETTLE and REVERT length in cycles (1..255)
//
// Ports:
//   clk        free-running control clock, independent of the switched clocks
//   rstn       synchronous active-low reset
//   req_valid  switch request
//   req_src    requested source (0 = clki[0], 1 = clki[1])
//   req_ready  high while a request can be accepted (IDLE, out of reset)
//   src_alive  per-source activity, already synchronised to clk
//   sel        clock switch select, always one-hot (registered)
//   ce         clock switch enables, set bit always matches sel (registered)
//   cur_src    currently committed source (registered)
//   busy       high in any state other than IDLE
//   done       single-cycle completion pulse
//   err        sticky failure flag, cleared by the next accepted request
module csb_switch_ctrl #(
  parameter        PRESELECT = "CLK0",
  parameter int    OFF_CYC   = 4,
  parameter int    SEL_CYC   = 2,
  parameter int    ON_CYC    = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  input  logic       req_src,
  output logic       req_ready,
  input  logic [1:0] src_alive,
  output logic [1:0] sel,
  output logic [1:0] ce,
  output logic       cur_src,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // An unsupported preselect or phase length is a configuration bug; stop
  // at elaboration rather than produce a switch with undefined behaviour.
  if (PRESELECT != "CLK0" && PRESELECT != "CLK1") begin : g_bad_preselect
    $fatal(1, "csb_switch_ctrl: PRESELECT must be \"CLK0\" or \"CLK1\"");
  end

  if (OFF_CYC < 1 || OFF_CYC > 255 || SEL_CYC < 1 || SEL_CYC > 255 ||
      ON_CYC < 1 || ON_CYC > 255) begin : g_bad_cycles
    $fatal(1, "csb_switch_ctrl: OFF_CYC, SEL_CYC and ON_CYC must be 1..255");
  end

  localparam logic       PRE_SRC = (PRESELECT == "CLK1");
  localparam logic [1:0] PRE_OH  = PRE_SRC ? 2'b10 : 2'b01;

  // The counter is loaded with length-1 and the phase ends when it reads 0,
  // so each phase occupies exactly its configured number of cycles.
  localparam logic [7:0] OFF_LD = 8'(OFF_CYC - 1);
  localparam logic [7:0] SEL_LD = 8'(SEL_CYC - 1);
  localparam logic [7:0] ON_LD  = 8'(ON_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    SWAP,
    SETTLE,
    REVERT
  } state_e;

  function automatic logic [1:0] onehot(input logic src);
    return src ? 2'b10 : 2'b01;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] cnt_q,   cnt_d;
  logic       tgt_q,   tgt_d;
  logic [1:0] sel_q,   sel_d;
  logic [1:0] ce_q,    ce_d;
  logic       cur_q,   cur_d;
  logic       done_q,  done_d;
  logic       err_q,   err_d;

  logic       accept;
  logic       tgt_alive;
  logic       cnt_zero;

  // req_ready is gated by rstn so no request can slip in while reset is held.
  assign req_ready = rstn && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign tgt_alive = src_alive[tgt_q];
  assign cnt_zero  = (cnt_q == 8'd0);

  assign sel     = sel_q;
  assign ce      = ce_q;
  assign cur_src = cur_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err     = err_q;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      tgt_q   <= PRE_SRC;
      sel_q   <= PRE_OH;
      ce_q    <= PRE_OH;
      cur_q   <= PRE_SRC;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      sel_q   <= sel_d;
      ce_q    <= ce_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. A dead target in SWAP or SETTLE takes priority over
  // the phase counter expiring, including on the last SETTLE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && (req_src != cur_q) && src_alive[req_src]) begin
          state_d = DRAIN;
          cnt_d   = OFF_LD;
        end
      end
      DRAIN: begin
        if (cnt_zero) begin
          state_d = SWAP;
          cnt_d   = SEL_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SWAP: begin
        if (!tgt_alive) begin
          state_d = REVERT;
          cnt_d   = ON_LD;
        end else if (cnt_zero) begin
          state_d = SETTLE;
          cnt_d   = ON_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SETTLE: begin
        if (!tgt_alive) begin
          state_d = REVERT;
          cnt_d   = ON_LD;
        end else if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      REVERT: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Output next values. sel and ce only change on state transitions, so the
  // enable is always dropped before the select moves and only raised once the
  // select has been stable for a full phase.
  always_comb begin
    tgt_d  = tgt_q;
    sel_d  = sel_q;
    ce_d   = ce_q;
    cur_d  = cur_q;
    done_d = 1'b0;
    err_d  = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_src == cur_q) begin
            done_d = 1'b1;
            err_d  = 1'b0;
          end else if (!src_alive[req_src]) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            err_d = 1'b0;
            tgt_d = req_src;
            ce_d  = ce_q & ~onehot(cur_q);
          end
        end
      end
      DRAIN: begin
        if (state_d == SWAP) begin
          sel_d = onehot(tgt_q);
          ce_d  = 2'b00;
        end
      end
      SWAP, SETTLE: begin
        if (state_d == REVERT) begin
          sel_d = onehot(cur_q);
          ce_d  = 2'b00;
        end else if (state_q == SWAP && state_d == SETTLE) begin
          ce_d = onehot(tgt_q);
        end else if (state_d == IDLE) begin
          cur_d  = tgt_q;
          done_d = 1'b1;
        end
      end
      REVERT: begin
        if (state_d == IDLE) begin
          ce_d   = onehot(cur_q);
          err_d  = 1'b1;
          done_d = 1'b1;
        end
      end
      default: begin
        sel_d = onehot(cur_q);
        ce_d  = onehot(cur_q);
      end
    endcase
  end

endmodule

// File: tb/tb_csb_switch_ctrl.sv
// tb_csb_switch_ctrl
//
// Bench for csb_switch_ctrl. dut0 uses the default parameters and is driven
// by directed requests followed by a long random phase; every request is
// turned into a transaction record (acceptance cycle, completion cycle,
// outcome) that is queued for the monitor. The monitor derives the expected
// sel/ce/busy/done/err/cur_src/req_ready of every cycle from the phase
// offsets of the transaction at the head of the queue and pops it on its
// completion cycle. dut1 (PRESELECT "CLK1") is used for the mid-sequence
// reset case.
module tb_csb_switch_ctrl;

  localparam int OFF = 4;
  localparam int SEL = 2;
  localparam int ON  = 4;

  typedef struct {
    int tAcc;
    int tDone;
    int dropOff;
    bit longSeq;
    bit tgt;
    bit curBefore;
    bit curAfter;
    bit errAfter;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0 signals
  logic       rstn, reqValid, reqSrc, reqReady;
  logic [1:0] srcAlive, sel, ce;
  logic       curSrc, busy, done, err;

  // dut1 signals
  logic       rstn1, reqValid1, reqSrc1, reqReady1;
  logic [1:0] srcAlive1, sel1, ce1;
  logic       curSrc1, busy1, done1, err1;

  int   errCount = 0;
  int   checkCount = 0;
  txn_t sbQ[$];
  bit   planCur = 1'b0;
  int   numAcc = 0;
  int   numDone = 0;
  int   lastDoneCyc = -1;
  bit   monEn = 1'b0;

  csb_switch_ctrl #(
    .PRESELECT ("CLK0"),
    .OFF_CYC   (OFF),
    .SEL_CYC   (SEL),
    .ON_CYC    (ON)
  ) dut0 (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (reqValid),
    .req_src   (reqSrc),
    .req_ready (reqReady),
    .src_alive (srcAlive),
    .sel       (sel),
    .ce        (ce),
    .cur_src   (curSrc),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  csb_switch_ctrl #(
    .PRESELECT ("CLK1"),
    .OFF_CYC   (OFF),
    .SEL_CYC   (SEL),
    .ON_CYC    (ON)
  ) dut1 (
    .clk       (clk),
    .rstn      (rstn1),
    .req_valid (reqValid1),
    .req_src   (reqSrc1),
    .req_ready (reqReady1),
    .src_alive (srcAlive1),
    .sel       (sel1),
    .ce        (ce1),
    .cur_src   (curSrc1),
    .busy      (busy1),
    .done      (done1),
    .err       (err1)
  );

  function automatic logic [1:0] oh(input bit src);
    return src ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] randomAlive();
    if ($urandom_range(0, 3) == 0) return 2'($urandom_range(0, 3));
    return 2'b11;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, actual, expected);
    end
  endtask

  // One idle cycle on dut0: no request, given liveness.
  task automatic idleCycle(input logic [1:0] a);
    @(negedge clk);
    reqValid = 1'b0;
    reqSrc   = 1'($urandom_range(0, 1));
    srcAlive = a;
  endtask

  // Issue a request on dut0 in the next cycle (the bench's model says dut0
  // is idle then), queue the expected outcome, and for a long sequence keep
  // driving until the cycle before completion. dropReq > 0 drops the
  // target's liveness at that offset from acceptance.
  task automatic applyStimulus(input bit src, input logic [1:0] a, input int dropReq,
                               output int tAcc);
    txn_t t;
    @(negedge clk);
    reqValid = 1'b1;
    reqSrc   = src;
    srcAlive = a;
    t.tAcc      = cyc;
    t.tgt       = src;
    t.curBefore = planCur;
    t.dropOff   = -1;
    t.longSeq   = 1'b0;
    if (src == planCur) begin
      t.tDone    = cyc + 1;
      t.curAfter = planCur;
      t.errAfter = 1'b0;
    end else if (!a[src]) begin
      t.tDone    = cyc + 1;
      t.curAfter = planCur;
      t.errAfter = 1'b1;
    end else begin
      t.longSeq = 1'b1;
      if (dropReq > 0) begin
        t.dropOff  = dropReq;
        t.tDone    = cyc + dropReq + ON + 1;
        t.curAfter = planCur;
        t.errAfter = 1'b1;
      end else begin
        t.tDone    = cyc + OFF + SEL + ON + 1;
        t.curAfter = src;
        t.errAfter = 1'b0;
      end
    end
    sbQ.push_back(t);
    numAcc++;
    planCur = t.curAfter;
    tAcc    = t.tAcc;
    if (t.longSeq) begin
      for (int c = t.tAcc + 1; c < t.tDone; c++) begin
        @(negedge clk);
        reqValid = 1'($urandom_range(0, 1));
        reqSrc   = 1'($urandom_range(0, 1));
        srcAlive[t.tgt]  = !(t.dropOff > 0 && (cyc - t.tAcc) >= t.dropOff);
        srcAlive[!t.tgt] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic checkLatency(input string name, input int tAcc, input int expLat);
    idleCycle(2'b11);
    idleCycle(2'b11);
    checkOutput(name, lastDoneCyc - tAcc, expLat);
  endtask

  // Monitor: expected outputs of every cycle from the head transaction.
  bit         mCur = 1'b0;
  bit         mErr = 1'b0;
  bit         active;
  txn_t       f;
  int         d;
  logic [1:0] expSel, expCe;
  bit         expBusy, expDone, expErr, expCur, expReady;

  always @(negedge clk) begin
    if (monEn) begin
      active = (sbQ.size() > 0) && (cyc > sbQ[0].tAcc);
      if (active) f = sbQ[0];
      if (!active) begin
        expSel = oh(mCur); expCe = oh(mCur); expBusy = 0; expDone = 0;
        expErr = mErr; expCur = mCur; expReady = 1;
      end else if (cyc == f.tDone) begin
        expSel = oh(f.curAfter); expCe = oh(f.curAfter); expBusy = 0; expDone = 1;
        expErr = f.errAfter; expCur = f.curAfter; expReady = 1;
      end else begin
        d = cyc - f.tAcc;
        expBusy = 1; expDone = 0; expErr = 0; expCur = f.curBefore; expReady = 0;
        if (f.dropOff > 0 && d > f.dropOff) begin
          expSel = oh(f.curBefore); expCe = 2'b00;
        end else if (d <= OFF) begin
          expSel = oh(f.curBefore); expCe = 2'b00;
        end else if (d <= OFF + SEL) begin
          expSel = oh(f.tgt); expCe = 2'b00;
        end else begin
          expSel = oh(f.tgt); expCe = oh(f.tgt);
        end
      end
      checkOutput("sel", int'(sel), int'(expSel));
      checkOutput("ce", int'(ce), int'(expCe));
      checkOutput("busy", int'(busy), int'(expBusy));
      checkOutput("done", int'(done), int'(expDone));
      checkOutput("err", int'(err), int'(expErr));
      checkOutput("cur_src", int'(curSrc), int'(expCur));
      checkOutput("req_ready", int'(reqReady), int'(expReady));
      checkOutput("sel_onehot", int'($onehot(sel)), 1);
      checkOutput("ce_not_11", int'(ce == 2'b11), 0);
      if (done === 1'b1) begin
        lastDoneCyc = cyc;
        numDone++;
      end
      if (active && cyc == f.tDone) begin
        mCur = f.curAfter;
        mErr = f.errAfter;
        void'(sbQ.pop_front());
      end
    end
  end

  initial begin
    int         tA;
    int         tEnd;
    int         drop;
    bit         src;
    logic [1:0] a;

    rstn = 1'b0; reqValid = 1'b0; reqSrc = 1'b0; srcAlive = 2'b11;
    rstn1 = 1'b0; reqValid1 = 1'b0; reqSrc1 = 1'b0; srcAlive1 = 2'b11;
    repeat (3) @(negedge clk);

    checkOutput("rst_sel", int'(sel), 1);
    checkOutput("rst_ce", int'(ce), 1);
    checkOutput("rst_cur", int'(curSrc), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_ready", int'(reqReady), 0);
    checkOutput("rst1_sel", int'(sel1), 2);
    checkOutput("rst1_ce", int'(ce1), 2);
    checkOutput("rst1_cur", int'(curSrc1), 1);
    rstn = 1'b1; rstn1 = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_rst", int'(reqReady), 1);
    checkOutput("ready1_after_rst", int'(reqReady1), 1);
    monEn = 1'b1;

    // dut1: reset during DRAIN aborts the switch without a done pulse.
    @(negedge clk);
    reqValid1 = 1'b1; reqSrc1 = 1'b0;
    @(negedge clk);
    reqValid1 = 1'b0;
    checkOutput("r1_drain_busy", int'(busy1), 1);
    checkOutput("r1_drain_sel", int'(sel1), 2);
    checkOutput("r1_drain_ce", int'(ce1), 0);
    @(negedge clk);
    @(negedge clk);
    rstn1 = 1'b0;
    @(negedge clk);
    checkOutput("r1_abort_sel", int'(sel1), 2);
    checkOutput("r1_abort_ce", int'(ce1), 2);
    checkOutput("r1_abort_busy", int'(busy1), 0);
    checkOutput("r1_abort_done", int'(done1), 0);
    checkOutput("r1_abort_ready", int'(reqReady1), 0);
    rstn1 = 1'b1;
    @(negedge clk);
    checkOutput("r1_release_ready", int'(reqReady1), 1);
    checkOutput("r1_release_cur", int'(curSrc1), 1);
    for (int i = 0; i < OFF + SEL + ON; i++) begin
      @(negedge clk);
      checkOutput("r1_no_done", int'(done1), 0);
    end

    // dut0 directed cases.
    applyStimulus(1'b1, 2'b11, -1, tA);
    checkLatency("lat_switch_0to1", tA, 11);
    applyStimulus(1'b0, 2'b11, -1, tA);
    checkLatency("lat_switch_1to0", tA, 11);
    applyStimulus(1'b0, 2'b11, -1, tA);
    checkLatency("lat_same_src", tA, 1);
    idleCycle(2'b01);
    applyStimulus(1'b1, 2'b01, -1, tA);
    checkLatency("lat_dead_target", tA, 1);
    applyStimulus(1'b1, 2'b11, 6, tA);
    checkLatency("lat_revert_swap", tA, 11);
    applyStimulus(1'b1, 2'b11, OFF + SEL + ON, tA);
    checkLatency("lat_revert_last", tA, OFF + SEL + 2 * ON + 1);

    // Random back-to-back traffic.
    tEnd = cyc + 10000;
    while (cyc < tEnd) begin
      if ($urandom_range(0, 2) == 0) begin
        a   = randomAlive();
        src = 1'($urandom_range(0, 1));
        drop = -1;
        if ($urandom_range(0, 2) == 0) drop = int'($urandom_range(OFF + 1, OFF + SEL + ON));
        applyStimulus(src, a, drop, tA);
      end else begin
        idleCycle(randomAlive());
      end
    end

    repeat (3) idleCycle(2'b11);
    checkOutput("sb_drained", sbQ.size(), 0);
    checkOutput("done_vs_accept", numDone, numAcc);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
